// File: rtl/mpu6050_sampler.sv
`timescale 1ns/1ps
// mpu6050_sampler: wakes the MPU-6050 through i2c_master, then reads the accel registers each sample tick.
// Define MPU6050_GYRO_READ_EN to extend every burst to the gyro registers (0x43..0x48).
module mpu6050_sampler #(
  parameter int unsigned CLK_HZ               = 100_000_000,
  parameter int unsigned SAMPLE_RATE_HZ       = 100,
  parameter int unsigned POWERUP_DELAY_CYCLES = 10_000_000,
  parameter int unsigned BUSY_TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic        i2c_enable,
  output logic        i2c_read_write,
  output logic [7:0]  i2c_register_address,
  output logic [7:0]  i2c_mosi_data,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_miso_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        error,
  output logic [7:0]  overrun_count
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned PERIOD = CLK_HZ / SAMPLE_RATE_HZ;
`ifdef MPU6050_GYRO_READ_EN
  localparam int unsigned N_READS = 12;
`else
  localparam int unsigned N_READS = 6;
`endif
  localparam int unsigned SHADOW_W = N_READS * 8;

  localparam logic [7:0] REG_PWR_MGMT_1 = 8'h6B;
  localparam logic [7:0] REG_ACCEL_XH   = 8'h3B;

  typedef enum logic [3:0] {
    S_POWERUP,
    S_SETUP,
    S_ENABLE,
    S_WAIT_HIGH,
    S_WAIT_LOW,
    S_CAPTURE,
    S_IDLE,
    S_PUBLISH,
    S_ERROR
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    delay_cnt;
  logic [CNT_W-1:0]    to_cnt;
  logic [CNT_W-1:0]    tick_cnt;
  logic [IDX_W-1:0]    idx;
  logic                wake_txn;
  logic [SHADOW_W-1:0] shadow;
  logic                tick_c;

  assign tick_c = run && init_done && (tick_cnt >= CNT_W'(PERIOD - 1));

  // Sample-period counter; held at zero whenever sampling is not permitted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!(run && init_done) || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_POWERUP;
      delay_cnt            <= '0;
      to_cnt               <= '0;
      idx                  <= '0;
      wake_txn             <= 1'b0;
      shadow               <= '0;
      i2c_enable           <= 1'b0;
      i2c_read_write       <= 1'b0;
      i2c_register_address <= '0;
      i2c_mosi_data        <= '0;
      accel_x              <= '0;
      accel_y              <= '0;
      accel_z              <= '0;
`ifdef MPU6050_GYRO_READ_EN
      gyro_x               <= '0;
      gyro_y               <= '0;
      gyro_z               <= '0;
`endif
      sample_valid         <= 1'b0;
      init_done            <= 1'b0;
      error                <= 1'b0;
      overrun_count        <= '0;
    end else begin
      sample_valid <= 1'b0;

      // A tick that cannot start a burst is dropped and counted.
      if (tick_c && (state != S_IDLE) && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end

      case (state)
        S_POWERUP: begin
          if (delay_cnt + CNT_W'(1) >= CNT_W'(POWERUP_DELAY_CYCLES)) begin
            delay_cnt            <= '0;
            wake_txn             <= 1'b1;
            i2c_read_write       <= 1'b0;
            i2c_register_address <= REG_PWR_MGMT_1;
            i2c_mosi_data        <= 8'h00;
            state                <= S_SETUP;
          end else begin
            delay_cnt <= delay_cnt + CNT_W'(1);
          end
        end

        S_SETUP: begin
          if (!i2c_busy) begin
            i2c_enable <= 1'b1;
            to_cnt     <= '0;
            state      <= S_ENABLE;
          end
        end

        S_ENABLE: begin
          if (i2c_busy) begin
            i2c_enable <= 1'b0;
            state      <= S_WAIT_HIGH;
          end else if (to_cnt + CNT_W'(1) >= CNT_W'(BUSY_TIMEOUT_CYCLES)) begin
            i2c_enable <= 1'b0;
            error      <= 1'b1;
            state      <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        S_WAIT_HIGH: begin
          to_cnt <= '0;
          state  <= S_WAIT_LOW;
        end

        S_WAIT_LOW: begin
          if (!i2c_busy) begin
            state <= S_CAPTURE;
          end else if (to_cnt + CNT_W'(1) >= CNT_W'(BUSY_TIMEOUT_CYCLES)) begin
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          if (wake_txn) begin
            wake_txn  <= 1'b0;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            // Bytes shift in from the bottom, so the first register read ends up in the top byte.
            shadow <= {shadow[SHADOW_W-9:0], i2c_miso_data};
            if (idx == IDX_W'(N_READS - 1)) begin
              state <= S_PUBLISH;
            end else begin
              idx <= idx + IDX_W'(1);
`ifdef MPU6050_GYRO_READ_EN
              i2c_register_address <= (i2c_register_address == 8'h40) ? 8'h43
                                                                       : i2c_register_address + 8'd1;
`else
              i2c_register_address <= i2c_register_address + 8'd1;
`endif
              state <= S_SETUP;
            end
          end
        end

        S_IDLE: begin
          if (tick_c) begin
            idx                  <= '0;
            i2c_read_write       <= 1'b1;
            i2c_register_address <= REG_ACCEL_XH;
            i2c_mosi_data        <= 8'h00;
            state                <= S_SETUP;
          end
        end

        S_PUBLISH: begin
          accel_x      <= shadow[SHADOW_W-1  -: 16];
          accel_y      <= shadow[SHADOW_W-17 -: 16];
          accel_z      <= shadow[SHADOW_W-33 -: 16];
`ifdef MPU6050_GYRO_READ_EN
          gyro_x       <= shadow[SHADOW_W-49 -: 16];
          gyro_y       <= shadow[SHADOW_W-65 -: 16];
          gyro_z       <= shadow[SHADOW_W-81 -: 16];
`endif
          sample_valid <= 1'b1;
          state        <= S_IDLE;
        end

        S_ERROR: begin
          i2c_enable <= 1'b0;
          if (!run) begin
            error     <= 1'b0;
            init_done <= 1'b0;
            delay_cnt <= '0;
            state     <= S_POWERUP;
          end
        end

        default: state <= S_POWERUP;
      endcase
    end
  end

`ifndef MPU6050_GYRO_READ_EN
  assign gyro_x = '0;
  assign gyro_y = '0;
  assign gyro_z = '0;
`endif

endmodule

// File: tb/tb_mpu6050_sampler.sv
`timescale 1ns/1ps
// Scoreboard bench for mpu6050_sampler: behavioural i2c_master models, expected transactions and samples queued ahead.
module tb_mpu6050_sampler;

  localparam int unsigned P_A = 2000;

  typedef struct packed { logic rw; logic [7:0] addr; logic [7:0] data; } txn_t;
  typedef struct packed { logic [15:0] ax, ay, az, gx, gy, gz; } smp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: main sampler, 50-cycle (then 3000-cycle) busy model
  logic rst_a, run_a, en_a, rw_a, busy_a, sv_a, init_a, err_a;
  logic [7:0] addr_a, mosi_a, miso_a, ov_a;
  logic [15:0] ax_a, ay_a, az_a, gx_a, gy_a, gz_a;

  mpu6050_sampler #(.CLK_HZ(P_A), .SAMPLE_RATE_HZ(1), .POWERUP_DELAY_CYCLES(100),
                    .BUSY_TIMEOUT_CYCLES(5000)) dut_a (
    .clock(clock), .reset_n(rst_a), .run(run_a), .i2c_enable(en_a), .i2c_read_write(rw_a),
    .i2c_register_address(addr_a), .i2c_mosi_data(mosi_a), .i2c_busy(busy_a), .i2c_miso_data(miso_a),
    .accel_x(ax_a), .accel_y(ay_a), .accel_z(az_a), .gyro_x(gx_a), .gyro_y(gy_a), .gyro_z(gz_a),
    .sample_valid(sv_a), .init_done(init_a), .error(err_a), .overrun_count(ov_a));

  logic [7:0] regs [256];
  int busy_len_a = 50;
  int cnt_a = 0;
  always @(negedge clock) begin
    if (!rst_a) begin
      busy_a = 1'b0; cnt_a = 0; miso_a = 8'h00;
    end else if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) busy_a = 1'b0;
    end else if (en_a && !busy_a) begin
      busy_a = 1'b1; cnt_a = busy_len_a;
      miso_a = rw_a ? regs[addr_a] : 8'h00;
    end
  end

  txn_t txq[$];
  smp_t smq[$];
  int unsigned txn_seen = 0, smp_seen = 0;
  logic en_a_q = 1'b0;
  txn_t t_got, t_exp;
  smp_t s_got, s_exp;

  // transaction monitor: every rising i2c_enable must match the next queued transaction
  always @(posedge clock) begin
    #1;
    if (en_a && !en_a_q) begin
      t_got = '{rw_a, addr_a, mosi_a};
      if (txq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL txn_unexpected: got %h expected none", t_got);
      end else begin
        t_exp = txq.pop_front();
        chk("txn", 32'(t_got), 32'(t_exp));
      end
      txn_seen++;
    end
    en_a_q = en_a;
  end

  // sample monitor
  always @(posedge clock) begin
    #1;
    if (sv_a) begin
      s_got = '{ax_a, ay_a, az_a, gx_a, gy_a, gz_a};
      if (smq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL sample_unexpected: got %h expected none", s_got);
      end else begin
        s_exp = smq.pop_front();
        chk("accel_x", 32'(s_got.ax), 32'(s_exp.ax));
        chk("accel_y", 32'(s_got.ay), 32'(s_exp.ay));
        chk("accel_z", 32'(s_got.az), 32'(s_exp.az));
        chk("gyro_x",  32'(s_got.gx), 32'(s_exp.gx));
        chk("gyro_y",  32'(s_got.gy), 32'(s_exp.gy));
        chk("gyro_z",  32'(s_got.gz), 32'(s_exp.gz));
      end
      smp_seen++;
    end
  end

  // overrun monitor: steps of exactly one, one sample period apart
  logic [7:0] ov_prev = 8'h00;
  int unsigned ov_cyc_prev = 0;
  always @(posedge clock) begin
    #1;
    if (ov_a != ov_prev) begin
      if (ov_a > ov_prev) begin
        chk("overrun_step", 32'(8'(ov_a - ov_prev)), 32'd1);
        if (ov_prev != 8'h00) chk("overrun_interval", cyc - ov_cyc_prev, P_A);
        ov_cyc_prev = cyc;
      end
      ov_prev = ov_a;
    end
  end

  // ---------------- instance B: busy never asserted, short timeout
  logic rst_b, run_b, en_b, rw_b, sv_b, init_b, err_b;
  logic busy_b = 1'b0;
  logic [7:0] miso_b = 8'h00;
  logic [7:0] addr_b, mosi_b, ov_b;
  logic [15:0] ax_b, ay_b, az_b, gx_b, gy_b, gz_b;

  mpu6050_sampler #(.CLK_HZ(P_A), .SAMPLE_RATE_HZ(1), .POWERUP_DELAY_CYCLES(100),
                    .BUSY_TIMEOUT_CYCLES(500)) dut_b (
    .clock(clock), .reset_n(rst_b), .run(run_b), .i2c_enable(en_b), .i2c_read_write(rw_b),
    .i2c_register_address(addr_b), .i2c_mosi_data(mosi_b), .i2c_busy(busy_b), .i2c_miso_data(miso_b),
    .accel_x(ax_b), .accel_y(ay_b), .accel_z(az_b), .gyro_x(gx_b), .gyro_y(gy_b), .gyro_z(gz_b),
    .sample_valid(sv_b), .init_done(init_b), .error(err_b), .overrun_count(ov_b));

  // ---------------- instance C: P = 20 with a 300-cycle busy, drives overrun into saturation
  logic rst_c, run_c, en_c, rw_c, sv_c, init_c, err_c;
  logic busy_c;
  logic [7:0] miso_c = 8'h00;
  logic [7:0] addr_c, mosi_c, ov_c;
  logic [15:0] ax_c, ay_c, az_c, gx_c, gy_c, gz_c;

  mpu6050_sampler #(.CLK_HZ(20), .SAMPLE_RATE_HZ(1), .POWERUP_DELAY_CYCLES(100),
                    .BUSY_TIMEOUT_CYCLES(5000)) dut_c (
    .clock(clock), .reset_n(rst_c), .run(run_c), .i2c_enable(en_c), .i2c_read_write(rw_c),
    .i2c_register_address(addr_c), .i2c_mosi_data(mosi_c), .i2c_busy(busy_c), .i2c_miso_data(miso_c),
    .accel_x(ax_c), .accel_y(ay_c), .accel_z(az_c), .gyro_x(gx_c), .gyro_y(gy_c), .gyro_z(gz_c),
    .sample_valid(sv_c), .init_done(init_c), .error(err_c), .overrun_count(ov_c));

  int cnt_c = 0;
  always @(negedge clock) begin
    if (!rst_c) begin
      busy_c = 1'b0; cnt_c = 0;
    end else if (cnt_c > 0) begin
      cnt_c--;
      if (cnt_c == 0) busy_c = 1'b0;
    end else if (en_c && !busy_c) begin
      busy_c = 1'b1; cnt_c = 300;
    end
  end

  // ---------------- stimulus helpers
  task automatic push_burst();
    for (int a = 8'h3B; a <= 8'h40; a++) txq.push_back('{1'b1, 8'(a), 8'h00});
`ifdef MPU6050_GYRO_READ_EN
    for (int a = 8'h43; a <= 8'h48; a++) txq.push_back('{1'b1, 8'(a), 8'h00});
`endif
  endtask

  task automatic push_sample(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az);
`ifdef MPU6050_GYRO_READ_EN
    smq.push_back('{ax, ay, az, 16'h0001, 16'h7FFF, 16'hFFFF});
`else
    smq.push_back('{ax, ay, az, 16'h0000, 16'h0000, 16'h0000});
`endif
  endtask

  task automatic set_accel(input logic [47:0] v);
    for (int i = 0; i < 6; i++) regs[8'h3B + i] = v[47 - 8*i -: 8];
  endtask

  task automatic wait_smp(input int unsigned n, input int unsigned budget, input string name);
    int unsigned k = 0;
    while (smp_seen < n && k < budget) begin @(posedge clock); #2; k++; end
    chk(name, 32'(smp_seen >= n), 32'd1);
  endtask

  task automatic wait_wake_a(input string name);
    int unsigned k = 0;
    int unsigned t0 = cyc;
    while (!en_a && k < 500) begin @(posedge clock); #2; k++; end
    chk({name, "_latency"}, 32'((cyc - t0 >= 99) && (cyc - t0 <= 105)), 32'd1);
    k = 0;
    while (!init_a && k < 1000) begin @(posedge clock); #2; k++; end
    chk({name, "_init_done"}, 32'(init_a), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, n, t_en, t_r;
    foreach (regs[i]) regs[i] = 8'h00;
    regs[8'h43] = 8'h00; regs[8'h44] = 8'h01; regs[8'h45] = 8'h7F;
    regs[8'h46] = 8'hFF; regs[8'h47] = 8'hFF; regs[8'h48] = 8'hFF;
    rst_a = 1'b0; run_a = 1'b0;
    rst_b = 1'b0; run_b = 1'b0;
    rst_c = 1'b0; run_c = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    chk("reset_enable",  32'(en_a),   32'd0);
    chk("reset_init",    32'(init_a), 32'd0);
    chk("reset_error",   32'(err_a),  32'd0);
    chk("reset_valid",   32'(sv_a),   32'd0);
    chk("reset_accel_x", 32'(ax_a),   32'd0);
    chk("reset_overrun", 32'(ov_a),   32'd0);

    // wake write after the power-up delay
    txq.push_back('{1'b0, 8'h6B, 8'h00});
    @(negedge clock); rst_a = 1'b1;
    wait_wake_a("wake");
    chk("no_error_after_wake", 32'(err_a), 32'd0);

    // burst 1
    set_accel(48'h1234_FF38_8000);
    push_burst(); push_sample(16'h1234, 16'hFF38, 16'h8000);
    run_a = 1'b1;
    wait_smp(1, 5000, "sample1_seen");

    // burst 2: boundary values
    set_accel(48'h0001_7FFF_FFFF);
    push_burst(); push_sample(16'h0001, 16'h7FFF, 16'hFFFF);
    wait_smp(2, 3000, "sample2_seen");

    // burst 3: run falls once the burst has started; it must still complete
    set_accel(48'hA55A_0000_7F00);
    push_burst(); push_sample(16'hA55A, 16'h0000, 16'h7F00);
    n = txn_seen; k = 0;
    while (txn_seen <= n && k < 3000) begin @(posedge clock); #2; k++; end
    chk("burst3_started", 32'(txn_seen > n), 32'd1);
    run_a = 1'b0;
    wait_smp(3, 2000, "sample_after_run_drop");
    n = txn_seen;
    repeat (4500) @(posedge clock);
    #2;
    chk("idle_no_txn",    txn_seen, n);
    chk("idle_no_sample", smp_seen, 32'd3);

    // slow i2c: ticks during the burst are counted as overruns
    busy_len_a = 3000;
    push_burst(); push_sample(16'hA55A, 16'h0000, 16'h7F00);
    run_a = 1'b1;
    wait_smp(4, 45000, "sample_slow_seen");
    run_a = 1'b0;
    chk("overrun_range", 32'((ov_a >= 8'd8) && (ov_a <= 8'd20)), 32'd1);

    // reset in the middle of the third read of a burst
    busy_len_a = 50;
    txq.push_back('{1'b1, 8'h3B, 8'h00});
    txq.push_back('{1'b1, 8'h3C, 8'h00});
    txq.push_back('{1'b1, 8'h3D, 8'h00});
    run_a = 1'b1;
    k = 0;
    while (!(en_a && addr_a == 8'h3D) && k < 5000) begin @(posedge clock); #2; k++; end
    chk("read3_reached", 32'(en_a && addr_a == 8'h3D), 32'd1);
    #1 rst_a = 1'b0;
    #1;
    chk("async_enable",  32'(en_a),   32'd0);
    chk("async_init",    32'(init_a), 32'd0);
    chk("async_accel_x", 32'(ax_a),   32'd0);
    chk("async_overrun", 32'(ov_a),   32'd0);
    chk("async_addr",    32'(addr_a), 32'd0);
    run_a = 1'b0;
    txq.push_back('{1'b0, 8'h6B, 8'h00});
    @(negedge clock); rst_a = 1'b1;
    wait_wake_a("rewake");

    // timeout: busy never rises
    @(negedge clock); rst_b = 1'b1; run_b = 1'b1;
    k = 0;
    while (!en_b && k < 500) begin @(posedge clock); #2; k++; end
    chk("b_enable_rose", 32'(en_b), 32'd1);
    t_en = cyc; k = 0;
    while (!err_b && k < 1000) begin @(posedge clock); #2; k++; end
    chk("b_error",          32'(err_b), 32'd1);
    chk("b_timeout_cycles", 32'((cyc - t_en >= 498) && (cyc - t_en <= 502)), 32'd1);
    chk("b_enable_low",     32'(en_b), 32'd0);
    chk("b_init_low",       32'(init_b), 32'd0);
    chk("b_valid_low",      32'(sv_b), 32'd0);
    run_b = 1'b0;
    t_r = cyc;
    repeat (3) @(posedge clock);
    #2;
    chk("b_error_cleared", 32'(err_b), 32'd0);
    k = 0;
    while (!en_b && k < 500) begin @(posedge clock); #2; k++; end
    chk("b_restart_latency", 32'((cyc - t_r >= 95) && (cyc - t_r <= 110)), 32'd1);
    chk("b_restart_wake", 32'({rw_b, addr_b, mosi_b}), 32'({1'b0, 8'h6B, 8'h00}));

    // saturation of overrun_count
    @(negedge clock); rst_c = 1'b1; run_c = 1'b1;
    repeat (9000) @(posedge clock);
    #2;
    chk("c_overrun_saturated", 32'(ov_c), 32'd255);
    repeat (300) @(posedge clock);
    #2;
    chk("c_overrun_held", 32'(ov_c), 32'd255);
    chk("c_no_error",     32'(err_c), 32'd0);

    chk("txq_drained", txq.size(), 32'd0);
    chk("smq_drained", smq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
